// File: rtl/dff_load_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : dff_load_arbiter_if
//  Purpose  : Bundles the requester handshake and the shared-register bus
//             seen by dff_load_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface dff_load_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [WIDTH-1:0]      q_in;
    logic                  load;
    logic [WIDTH-1:0]      d;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic [NREQ-1:0]       err;

    // Arbiter side: consumes requests and readback, drives grant/response/register.
    modport slave (
        input  req, req_data, q_in,
        output load, d, gnt, done, err
    );

    // Environment side: requesters plus the register readback.
    modport master (
        output req, req_data, q_in,
        input  load, d, gnt, done, err
    );
endinterface
`default_nettype wire

// File: rtl/dff_load_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dff_load_arbiter
//  Purpose  : Round-robin sharing of a WIDTH-bit load register among NREQ
//             requesters, with readback verification, bounded retries and a
//             one-cycle done/err pulse back to the granted requester.
//  Revision : 1.0  initial release
// ============================================================================
module dff_load_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 4,
    parameter int RETRIES = 1
) (
    input  wire logic            clk,
    input  wire logic            reset,
    dff_load_arbiter_if.slave    bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int RW = 2;

    typedef enum logic [1:0] {
        c_idle  = 2'd0,
        c_write = 2'd1,
        c_check = 2'd2,
        c_resp  = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [IW-1:0]     r_ptr, w_ptr_nxt;
    logic [IW-1:0]     r_idx, w_idx_nxt;
    logic [WIDTH-1:0]  r_wdata, w_wdata_nxt;
    logic [RW-1:0]     r_retry, w_retry_nxt;
    logic [NREQ-1:0]   r_gnt, w_gnt_nxt;
    logic              r_load, w_load_nxt;
    logic [WIDTH-1:0]  r_d, w_d_nxt;
    logic [NREQ-1:0]   r_done, w_done_nxt;
    logic [NREQ-1:0]   r_err, w_err_nxt;

    logic              w_any;
    logic [IW-1:0]     w_win;
    logic [WIDTH-1:0]  w_win_data;
    logic [NREQ-1:0]   w_win_oh;
    int                w_pos;

    // Round-robin search: first set request at or above ptr, wrapping round.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_pos = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_pos = int'(r_ptr) + k;
            if (w_pos >= NREQ) begin
                w_pos = w_pos - NREQ;
            end
            if (!w_any && bus.req[w_pos]) begin
                w_any = 1'b1;
                w_win = IW'(w_pos);
            end
        end
    end

    assign w_win_data = bus.req_data[int'(w_win)*WIDTH +: WIDTH];
    assign w_win_oh   = {{(NREQ-1){1'b0}}, 1'b1} << w_win;

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_idx_nxt   = r_idx;
        w_wdata_nxt = r_wdata;
        w_retry_nxt = r_retry;
        w_gnt_nxt   = r_gnt;
        w_load_nxt  = 1'b0;
        w_d_nxt     = r_d;
        w_done_nxt  = '0;
        w_err_nxt   = '0;
        case (r_state)
            c_idle: begin
                w_gnt_nxt = '0;
                w_d_nxt   = '0;
                if (w_any) begin
                    w_state_nxt = c_write;
                    w_idx_nxt   = w_win;
                    w_wdata_nxt = w_win_data;
                    w_retry_nxt = RW'(RETRIES);
                    w_load_nxt  = 1'b1;
                    w_d_nxt     = w_win_data;
                    w_gnt_nxt   = w_win_oh;
                end
            end
            c_write: begin
                w_state_nxt = c_check;
                w_d_nxt     = r_wdata;
            end
            c_check: begin
                // Grant is one-hot on the winner, so it doubles as the response mask.
                if (bus.q_in == r_wdata) begin
                    w_state_nxt = c_resp;
                    w_done_nxt  = r_gnt;
                end else if (r_retry != '0) begin
                    w_state_nxt = c_write;
                    w_retry_nxt = r_retry - RW'(1);
                    w_load_nxt  = 1'b1;
                end else begin
                    w_state_nxt = c_resp;
                    w_err_nxt   = r_gnt;
                end
            end
            c_resp: begin
                w_state_nxt = c_idle;
                w_gnt_nxt   = '0;
                w_d_nxt     = '0;
                w_ptr_nxt   = (r_idx == IW'(NREQ-1)) ? '0 : r_idx + IW'(1);
            end
            default: begin
                w_state_nxt = c_idle;
                w_gnt_nxt   = '0;
                w_d_nxt     = '0;
            end
        endcase
    end

    // State and output registers; reset discards any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_idle;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_retry <= '0;
            r_gnt   <= '0;
            r_load  <= 1'b0;
            r_d     <= '0;
            r_done  <= '0;
            r_err   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_idx   <= w_idx_nxt;
            r_wdata <= w_wdata_nxt;
            r_retry <= w_retry_nxt;
            r_gnt   <= w_gnt_nxt;
            r_load  <= w_load_nxt;
            r_d     <= w_d_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign bus.gnt  = r_gnt;
    assign bus.load = r_load;
    assign bus.d    = r_d;
    assign bus.done = r_done;
    assign bus.err  = r_err;

endmodule
`default_nettype wire

// File: doc/dff_load_arbiter.md
# dff_load_arbiter

Round-robin controller that shares the 4-bit `dff` load register among NREQ requesters. It grants one requester at a time and drives the register's `load` and `d` inputs with that requester's data. It then reads back `q` to confirm the write and returns a one-cycle `done` or `err` pulse to the granted requester. It sits directly in front of the `dff` instance, and its outputs are the only drivers of that register's `load`/`d`.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 4, data width; equals the `dff` register width
- RETRIES, 1, extra write attempts after a readback mismatch before `err` (0..3)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- req  in  NREQ  per-requester write request; held until `done`/`err`
- req_data  in  NREQ*WIDTH  per-requester write data; slice i = bits [i*WIDTH +: WIDTH]
- q_in  in  WIDTH  readback from the register's `q` output
- load  out  1  to register `load`
- d  out  WIDTH  to register `d`
- gnt  out  NREQ  one-hot grant, registered
- done  out  NREQ  one-cycle pulse: write of granted requester verified
- err  out  NREQ  one-cycle pulse: write failed after all retries

## Operation
- FSM states: IDLE, WRITE, CHECK, RESP. All outputs come from registers.
- **IDLE**
  - `gnt`, `load`, `done` and `err` are 0.
  - If any `req` is set, select the first set bit, searching upward from `ptr` with wrap-around.
  - Latch that requester's `req_data` slice into `wdata`, latch its index, load the retry counter with RETRIES, and go to WRITE.
- **WRITE**
  - `load`=1, `d`=`wdata`, `gnt` one-hot on the winner.
  - Always go to CHECK next cycle.
- **CHECK**
  - `load`=0, `gnt` held.
  - If `q_in`==`wdata`, go to RESP with `done` set.
  - Else if the retry count is >0, decrement it and go to WRITE.
  - Else go to RESP with `err` set.
- **RESP**
  - `gnt` held; exactly one of `done[idx]`/`err[idx]` is 1 for this one cycle.
  - `ptr` ← (idx+1) mod NREQ.
  - Go to IDLE.
- `d` holds `wdata` in CHECK and RESP. `d` returns to 0 in IDLE.
- `req_data` is sampled only on the IDLE→WRITE edge. Later changes are ignored.
- Dropping `req` mid-transaction does not abort the transaction. It completes, and `done`/`err` still pulse.
- A requester that keeps `req` high after `done` is re-arbitrated normally. Round-robin order means it is served again only after the other pending requesters.
- Readback mismatch caused by an external register reset is treated as an ordinary mismatch.

## Timing
- `reset`=0, asynchronous, forces immediately:
  - state=IDLE, `ptr`=0, `wdata`=0
  - `gnt`=0, `load`=0, `d`=0, `done`=0, `err`=0
- Release of `reset` takes effect on the next rising `clk`.
- Reset mid-transaction discards the transaction: no `done`/`err` is issued.
- Cycle numbering: `req` is sampled high in IDLE at edge E0.
  - Cycle 1 (after E0): WRITE, `load`=1. The register captures `d` at edge E1.
  - Cycle 2: CHECK; `q_in` is valid.
  - Cycle 3: RESP; `done`/`err` is high.
  - Cycle 4: IDLE; the next arbitration happens at the end of cycle 4.
- Latency from `req` sampled to `done`: 3 cycles.
- Throughput: one transaction per 4 cycles. Each retry adds 2 cycles (WRITE+CHECK).
- `load` is never high for two consecutive cycles.
- `gnt` is stable and one-hot from WRITE through RESP, and zero in IDLE.
- Simultaneous requests are resolved solely by `ptr`. Requester `ptr` has the highest priority, descending with wrap-around.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles with all `req`=1.
  - Required: `gnt`=0, `load`=0, `d`=0, `done`=0, `err`=0 throughout.
  - After release, the first grant is `gnt`=4'b0001.
- **Single write:** NREQ=4, `req`=4'b0100, data slice 2=4'hA, with a behavioural `dff` model on `q_in`.
  - Required: `load`=1 with `d`=4'hA in cycle 1 only.
  - `gnt`=4'b0100 in cycles 1–3.
  - `done`=4'b0100 in cycle 3; register `q`=4'hA.
- **Fairness:** all four `req` held high with distinct data 1,2,3,4.
  - Required: grant order 0,1,2,3,0, grants 4 cycles apart.
  - Each `done` arrives on its own requester's bit.
- **Mismatch:** RETRIES=1, `q_in` forced to 4'h0, request data 4'h5.
  - Required: WRITE in cycles 1 and 3 (`load` pulsed twice).
  - `err` pulse in cycle 5; no `done`.
- **Reset mid-operation:** assert `reset` in a WRITE cycle.
  - Required: `load`/`gnt` drop to 0 before the next edge, with no `done`.
  - After release, arbitration restarts from requester 0.
- **Request withdrawn:** drop `req[1]` during CHECK.
  - Required: `done[1]` still pulses in RESP, and the FSM returns to IDLE.
